corr_ram_dump_reader: RTL and testbench
=======================================

// Module: corr_ram_dump_reader
// PURPOSE
//  Host-side read initiator for the multi-tau correlator result RAMs. On a start pulse it sweeps the
//  five correlator banks (0x1000-0x101F, 0x2000-0x203F, 0x3000-0x307F, 0x4000-0x40FF, 0x5000-0x51FF).
//  It drives the 16-bit RamAddr bus, captures the 32-bit RamData after the RAM read latency, and emits
//  a header plus data words per bank on a valid/ready stream toward the host link FIFO.
// PARAMETERS
//  RAM_LATENCY  1   cycles from RamAddr change to valid RamData (1..7)
//  NUM_BANKS    5   number of correlator banks, selected by RamAddr[15:12] = 1..NUM_BANKS
//  BASE_DEPTH   32  depth of bank 1; bank n depth = BASE_DEPTH << (n-1)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   one-cycle pulse, begin a dump (honoured only in IDLE)
//  abort       in   1   one-cycle pulse, terminate a dump in progress
//  RamAddr     out  16  read address to bank read mux
//  RamData     in   32  read data from bank read mux
//  dout        out  32  stream word (header or RAM data)
//  dout_valid  out  1   dout holds a word
//  dout_ready  in   1   consumer accepts dout this cycle when valid&ready
//  busy        out  1   high from cycle after accepted start until DONE exit
//  ram_hold    out  1   = busy; freezes correlator accumulation during dump
//  done        out  1   one-cycle pulse after last word of bank NUM_BANKS accepted
// BEHAVIOUR
//  Reset: state IDLE, RamAddr=16'h0000, dout=0, dout_valid=0, busy=0, ram_hold=0, done=0,
//   bank=1, idx=0, wait counter=0. All outputs registered.
//  FSM: IDLE -> HDR -> ISSUE -> WAIT -> OUT -> (ISSUE | HDR | DONE) -> IDLE.
//  IDLE: RamAddr=0, dout_valid=0. start&!abort -> bank=1, idx=0, HDR. First header valid on the
//   next cycle.
//  HDR: dout={8'hA5, bank[3:0], 4'h0, depth[15:0]}, dout_valid=1; on valid&ready -> ISSUE.
//  ISSUE: RamAddr={bank[3:0], idx[11:0]}, wait counter=RAM_LATENCY -> WAIT.
//  WAIT: RamAddr held stable. Counter decrements each cycle. At 0, dout<=RamData, dout_valid=1 -> OUT.
//  OUT: dout and RamAddr held while !dout_ready. On accept:
//   - idx<depth-1: idx++, go to ISSUE.
//   - idx==depth-1 and bank<NUM_BANKS: bank++, idx=0, go to HDR.
//   - else go to DONE.
//  DONE: done=1 for one cycle, busy=0 next, RamAddr=0 -> IDLE.
//  Throughput: one data word per RAM_LATENCY+2 cycles with ready held high.
//   Stream totals: 992 data words plus 5 headers = 997 words (defaults).
//  start while busy: ignored. start and abort in the same cycle: abort wins.
//  abort in any non-IDLE state: next cycle IDLE, dout_valid=0 (sole exception to
//   valid-held-until-ready), busy=0, RamAddr=0, no done pulse. Bank and idx reset to 1 and 0.
//  dout_ready ignored when dout_valid=0. dout stable while valid&!ready.
//  idx width 12 bits; depth computed as 16-bit value; bank width 4 bits; no wrap beyond NUM_BANKS.
//  Async reset mid-dump returns to reset values immediately; no partial done.
// STRUCTURE
//  Shared package corr_pkg: bank base/select constants (BANK_SEL_A..E = 4'd1..5), BASE_DEPTH,
//   HDR_MAGIC=8'hA5, the state enum, and the default-read value 32'hAAAAAAAA.
//  Single module; no sub-module needed. The bank depth shift and address formation stay inline.
// TESTING
//  1 Full dump, ready=1, LAT=1, RAM model returns data=address:
//    -> 997 words; first word 0xA5100020, then 0x00001000..0x0000101F.
//    -> last header 0xA5500200; last data word 0x000051FF; done pulse once; busy low after.
//  2 Backpressure: ready low 10 cycles on word idx 7 of bank 3 -> dout=0x00003007 and
//    RamAddr=0x3007 stable for all 10 cycles; no words lost or duplicated.
//  3 RAM_LATENCY=3 -> every data word matches its address.
//    -> spacing between accepted data words is 5 cycles with ready=1.
//  4 abort during bank 4 at idx 100 -> next cycle IDLE, dout_valid=0, RamAddr=0, no done.
//    -> a new start yields a complete 997-word dump.
//  5 start pulsed while busy, plus start&abort together in IDLE -> both ignored; stream unchanged.
//  6 rst_n low mid bank 2 -> outputs at reset values asynchronously.
//    -> after release, idle until start.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared constants and types for the correlator result-RAM dump path.
//   Bank select codes, bank base addresses, bank-1 depth, stream header
//   magic, the value an unmapped RAM read returns, and the reader state type.
package corr_pkg;

  localparam logic [3:0] BANK_SEL_A = 4'd1;
  localparam logic [3:0] BANK_SEL_B = 4'd2;
  localparam logic [3:0] BANK_SEL_C = 4'd3;
  localparam logic [3:0] BANK_SEL_D = 4'd4;
  localparam logic [3:0] BANK_SEL_E = 4'd5;

  localparam logic [15:0] BANK_BASE_A = {BANK_SEL_A, 12'h000};
  localparam logic [15:0] BANK_BASE_B = {BANK_SEL_B, 12'h000};
  localparam logic [15:0] BANK_BASE_C = {BANK_SEL_C, 12'h000};
  localparam logic [15:0] BANK_BASE_D = {BANK_SEL_D, 12'h000};
  localparam logic [15:0] BANK_BASE_E = {BANK_SEL_E, 12'h000};

  localparam int          BASE_DEPTH   = 32;
  localparam logic [7:0]  HDR_MAGIC    = 8'hA5;
  localparam logic [31:0] DEFAULT_READ = 32'hAAAAAAAA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

endpackage

// File: rtl/corr_ram_dump_reader.sv
// Host-side read initiator for the multi-tau correlator result RAMs.
// On a start pulse it sweeps banks 1..NUM_BANKS, emitting one header word and
// then every data word of each bank on a valid/ready stream.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_start      one-cycle pulse, begin a dump (honoured only when idle)
//   i_abort      one-cycle pulse, terminate a dump in progress
//   o_ram_addr   read address {bank, idx} to the bank read mux
//   i_ram_data   read data from the bank read mux
//   o_dout       stream word (header or RAM data)
//   o_dout_valid o_dout holds a word
//   i_dout_ready consumer accepts o_dout when valid & ready
//   o_busy       dump in progress
//   o_ram_hold   freezes correlator accumulation; equals o_busy
//   o_done       one-cycle pulse after the final word is accepted
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, address bus parked at 0
// S_HDR   | bank header presented, waiting for accept
// S_ISSUE | drive {bank, idx} onto the address bus, load latency timer
// S_WAIT  | address held, timer counts down, RAM data captured at 0
// S_OUT   | data word presented, waiting for accept, then step idx/bank
// S_DONE  | done pulse visible, busy drops on exit
module corr_ram_dump_reader
  import corr_pkg::*;
#(
  parameter int RAM_LATENCY = 1,
  parameter int NUM_BANKS   = 5,
  parameter int BASE_DEPTH  = corr_pkg::BASE_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  output logic [15:0] o_ram_addr,
  input  logic [31:0] i_ram_data,
  output logic [31:0] o_dout,
  output logic        o_dout_valid,
  input  logic        i_dout_ready,
  output logic        o_busy,
  output logic        o_ram_hold,
  output logic        o_done
);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_ram_addr, w_ram_addr_nxt;
  logic [31:0] r_dout, w_dout_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic [3:0]  r_bank, w_bank_nxt;
  logic [11:0] r_idx, w_idx_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [15:0] w_depth;
  logic        w_last_idx;

  function automatic logic [31:0] hdr_for(input logic [3:0] b);
    logic [15:0] d;
    d = 16'(BASE_DEPTH) << (b - 4'd1);
    return {HDR_MAGIC, b, 4'h0, d};
  endfunction

  assign w_depth    = 16'(BASE_DEPTH) << (r_bank - 4'd1);
  assign w_last_idx = ({4'h0, r_idx} == (w_depth - 16'd1));

  always_comb begin
    w_state_nxt    = r_state;
    w_ram_addr_nxt = r_ram_addr;
    w_dout_nxt     = r_dout;
    w_valid_nxt    = r_valid;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_bank_nxt     = r_bank;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;

    case (r_state)
      S_IDLE: begin
        w_ram_addr_nxt = 16'h0000;
        w_valid_nxt    = 1'b0;
        if (i_start && !i_abort) begin
          w_bank_nxt  = BANK_SEL_A;
          w_idx_nxt   = 12'h000;
          w_dout_nxt  = hdr_for(BANK_SEL_A);
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (i_dout_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_ram_addr_nxt = {r_bank, r_idx};
        w_cnt_nxt      = 3'(RAM_LATENCY);
        w_state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        // Capture on the edge that takes the timer to zero, so the address
        // has been stable for exactly RAM_LATENCY cycles.
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_dout_nxt  = i_ram_data;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (i_dout_ready) begin
          w_valid_nxt = 1'b0;
          if (!w_last_idx) begin
            w_idx_nxt   = r_idx + 12'd1;
            w_state_nxt = S_ISSUE;
          end else if (r_bank < 4'(NUM_BANKS)) begin
            w_bank_nxt  = r_bank + 4'd1;
            w_idx_nxt   = 12'h000;
            w_dout_nxt  = hdr_for(r_bank + 4'd1);
            w_valid_nxt = 1'b1;
            w_state_nxt = S_HDR;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_busy_nxt     = 1'b0;
        w_ram_addr_nxt = 16'h0000;
        w_bank_nxt     = BANK_SEL_A;
        w_idx_nxt      = 12'h000;
        w_state_nxt    = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a pending header or data word.
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt    = S_IDLE;
      w_valid_nxt    = 1'b0;
      w_busy_nxt     = 1'b0;
      w_done_nxt     = 1'b0;
      w_ram_addr_nxt = 16'h0000;
      w_bank_nxt     = BANK_SEL_A;
      w_idx_nxt      = 12'h000;
      w_cnt_nxt      = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ram_addr <= 16'h0000;
      r_dout     <= 32'h0000_0000;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bank     <= BANK_SEL_A;
      r_idx      <= 12'h000;
      r_cnt      <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_dout     <= w_dout_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_bank     <= w_bank_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign o_ram_addr   = r_ram_addr;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_valid;
  assign o_busy       = r_busy;
  assign o_ram_hold   = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_corr_ram_dump_reader.sv
// Scoreboard bench for corr_ram_dump_reader: one instance at RAM latency 1,
// one at latency 3, each with its own RAM model, expected-word queue and monitor.
module tb_corr_ram_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  logic        start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b1;
  logic [15:0] addr1;
  logic [31:0] rdata1, dout1;
  logic        valid1, busy1, hold1, done1;

  logic        start3 = 1'b0, abort3 = 1'b0, ready3 = 1'b1;
  logic [15:0] addr3;
  logic [31:0] rdata3, dout3;
  logic        valid3, busy3, hold3, done3;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [31:0] w;
    logic        hdr;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  logic [31:0] salt1 = 32'h0;
  bit          rmode1 = 1'b0;
  bit          spc_en1 = 1'b0;
  int          done_cnt1 = 0, done_cnt3 = 0;

  corr_ram_dump_reader #(.RAM_LATENCY(1), .NUM_BANKS(5), .BASE_DEPTH(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_abort(abort1),
    .o_ram_addr(addr1), .i_ram_data(rdata1), .o_dout(dout1),
    .o_dout_valid(valid1), .i_dout_ready(ready1), .o_busy(busy1),
    .o_ram_hold(hold1), .o_done(done1)
  );

  corr_ram_dump_reader #(.RAM_LATENCY(3), .NUM_BANKS(5), .BASE_DEPTH(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(start3), .i_abort(abort3),
    .o_ram_addr(addr3), .i_ram_data(rdata3), .o_dout(dout3),
    .o_dout_valid(valid3), .i_dout_ready(ready3), .o_busy(busy3),
    .o_ram_hold(hold3), .o_done(done3)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents: mapped locations hold their own address (optionally salted),
  // anything else reads as the default pattern.
  function automatic logic [31:0] ram_fn(input logic [15:0] a, input logic [31:0] s);
    int b;
    int d;
    b = int'(a[15:12]);
    if (b < 1 || b > 5) return 32'hAAAAAAAA;
    d = 32 * (2 ** (b - 1));
    if (int'(a[11:0]) >= d) return 32'hAAAAAAAA;
    return {16'h0000, a} ^ s;
  endfunction

  // Latency 1: data valid within the cycle after the address changes.
  assign rdata1 = ram_fn(addr1, salt1);

  // Latency 3: data reflects the address from two edges ago.
  logic [15:0] a3_d1 = 16'h0, a3_d2 = 16'h0;
  always @(posedge clk) begin
    a3_d1 <= addr3;
    a3_d2 <= a3_d1;
  end
  assign rdata3 = ram_fn(a3_d2, 32'h0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_dump(input int which, input logic [31:0] s);
    exp_t e;
    for (int b = 1; b <= 5; b++) begin
      int d;
      d = 32 * (2 ** (b - 1));
      e.w   = 32'hA500_0000 | (32'(b) << 20) | 32'(d);
      e.hdr = 1'b1;
      if (which == 1) q1.push_back(e); else q3.push_back(e);
      for (int i = 0; i < d; i++) begin
        e.w   = (32'(b) * 32'd4096 + 32'(i)) ^ s;
        e.hdr = 1'b0;
        if (which == 1) q1.push_back(e); else q3.push_back(e);
      end
    end
  endtask

  // Monitor for the latency-1 instance.
  exp_t e1;
  int   last_hs1 = 0;
  bit   last_data1 = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("hold1_eq_busy1", hold1, busy1);
      if (start1) last_data1 = 1'b0;
      if (valid1 && ready1) begin
        chk("dump1_queue_nonempty", (q1.size() != 0), 1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          chk("dump1_word", dout1, e1.w);
          if (spc_en1 && !e1.hdr && last_data1) chk("dump1_spacing", cyc - last_hs1, 3);
          last_hs1   = cyc;
          last_data1 = !e1.hdr;
        end
      end
      if (done1) begin
        done_cnt1++;
        chk("done1_all_words_out", q1.size(), 0);
      end
    end
  end

  // Monitor for the latency-3 instance; ready is held high throughout.
  exp_t e3;
  int   last_hs3 = 0;
  bit   last_data3 = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("hold3_eq_busy3", hold3, busy3);
      if (start3) last_data3 = 1'b0;
      if (valid3 && ready3) begin
        chk("dump3_queue_nonempty", (q3.size() != 0), 1);
        if (q3.size() != 0) begin
          e3 = q3.pop_front();
          chk("dump3_word", dout3, e3.w);
          if (!e3.hdr && last_data3) chk("dump3_spacing", cyc - last_hs3, 5);
          last_hs3   = cyc;
          last_data3 = !e3.hdr;
        end
      end
      if (done3) begin
        done_cnt3++;
        chk("done3_all_words_out", q3.size(), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rmode1) ready1 = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_dump(input int which, input logic [31:0] s);
    if (which == 1) salt1 = s;
    push_dump(which, s);
    if (which == 1) start1 = 1'b1; else start3 = 1'b1;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
    if (which == 1) begin
      chk("start1_hdr_valid", valid1, 1);
      chk("start1_busy", busy1, 1);
      chk("start1_first_hdr", dout1, 32'hA510_0020);
    end else begin
      chk("start3_hdr_valid", valid3, 1);
      chk("start3_busy", busy3, 1);
      chk("start3_first_hdr", dout3, 32'hA510_0020);
    end
  endtask

  task automatic wait_done(input int which, input int limit, input bit poke);
    int  n;
    int  d0;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    d0   = (which == 1) ? done_cnt1 : done_cnt3;
    while (!seen && n < limit) begin
      tick();
      n++;
      seen = (which == 1) ? done1 : done3;
      if (poke && !seen) start1 = ($urandom_range(0, 49) == 0);
      else start1 = 1'b0;
    end
    chk("dump_done_within_budget", seen, 1);
    tick();
    if (which == 1) begin
      chk("done1_count", done_cnt1 - d0, 1);
      chk("after_done1_busy", busy1, 0);
      chk("after_done1_valid", valid1, 0);
      chk("after_done1_addr", addr1, 0);
      chk("after_done1_done_low", done1, 0);
    end else begin
      chk("done3_count", done_cnt3 - d0, 1);
      chk("after_done3_busy", busy3, 0);
      chk("after_done3_addr", addr3, 0);
    end
  endtask

  task automatic wait_addr1(input string name, input logic [15:0] a, input logic [15:0] m,
                            input int limit);
    int n;
    n = 0;
    while (!(((addr1 & m) == a) && !valid1) && n < limit) begin
      tick();
      n++;
    end
    chk(name, addr1 & m, a);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr1"}, addr1, 0);
    chk({tag, "_dout1"}, dout1, 0);
    chk({tag, "_valid1"}, valid1, 0);
    chk({tag, "_busy1"}, busy1, 0);
    chk({tag, "_hold1"}, hold1, 0);
    chk({tag, "_done1"}, done1, 0);
    chk({tag, "_addr3"}, addr3, 0);
    chk({tag, "_valid3"}, valid3, 0);
    chk({tag, "_busy3"}, busy3, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();

    // Latency 3: every word equals its address, data words five cycles apart.
    start_dump(3, 32'h0);
    wait_done(3, 8000, 1'b0);

    // Latency 1, ready held high: full 997-word stream, three-cycle spacing.
    rmode1  = 1'b0;
    ready1  = 1'b1;
    spc_en1 = 1'b1;
    start_dump(1, 32'h0);
    wait_done(1, 5000, 1'b0);
    spc_en1 = 1'b0;

    // Backpressure on bank 3 idx 7 for ten cycles.
    start_dump(1, 32'h0);
    wait_addr1("bp_reach_3007", 16'h3007, 16'hFFFF, 3000);
    ready1 = 1'b0;
    for (int n = 0; n < 10 && !valid1; n++) tick();
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid_held", valid1, 1);
      chk("bp_dout_stable", dout1, 32'h0000_3007);
      chk("bp_addr_stable", addr1, 16'h3007);
      tick();
    end
    ready1 = 1'b1;
    wait_done(1, 5000, 1'b0);

    // start together with abort while idle is ignored.
    start1 = 1'b1;
    abort1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("start_abort_idle_busy", busy1, 0);
      chk("start_abort_idle_valid", valid1, 0);
      tick();
    end

    // Random ready, salted data, stray start pulses while busy.
    rmode1 = 1'b1;
    start_dump(1, $urandom);
    wait_done(1, 8000, 1'b1);

    // Abort during bank 4 at idx 100, then a complete dump.
    begin
      int d0;
      d0 = done_cnt1;
      start_dump(1, $urandom);
      wait_addr1("abort_reach_4064", 16'h4064, 16'hFFFF, 8000);
      abort1 = 1'b1;
      tick();
      abort1 = 1'b0;
      chk("abort_valid", valid1, 0);
      chk("abort_addr", addr1, 0);
      chk("abort_busy", busy1, 0);
      chk("abort_hold", hold1, 0);
      q1.delete();
      for (int k = 0; k < 5; k++) begin
        tick();
        chk("abort_no_done", done1, 0);
        chk("abort_stays_idle", valid1, 0);
      end
      chk("abort_done_count", done_cnt1 - d0, 0);
    end
    start_dump(1, $urandom);
    wait_done(1, 8000, 1'b0);

    // Asynchronous reset in the middle of bank 2.
    rmode1 = 1'b0;
    ready1 = 1'b1;
    start_dump(1, $urandom);
    wait_addr1("rst_reach_bank2", 16'h2000, 16'hF000, 3000);
    for (int k = 0; k < int'($urandom_range(0, 20)); k++) tick();
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    q1.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("post_rst_idle_busy", busy1, 0);
      chk("post_rst_idle_valid", valid1, 0);
      chk("post_rst_idle_addr", addr1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
